// File: rtl/clct_cclut_builder_if.sv
// ============================================================================
// Module      : clct_cclut_builder_if
// Description : Candidate, LUT, threshold and CLCT output bundle between the
//               ccLUT pattern lookup stage and the CLCT builder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clct_cclut_builder_if #(
  parameter int MXKEYB  = 8,
  parameter int MXHITB  = 3,
  parameter int MXPIDB  = 4,
  parameter int MXOFFSB = 4,
  parameter int MXBNDB  = 5,
  parameter int MXQLTB  = 9,
  parameter int MXCNTB  = 16
);
  // Pattern candidates, cycle N
  logic                     pat_vld0, pat_vld1;
  logic [MXKEYB-1:0]        hs_key0, hs_key1;
  logic [MXHITB+MXPIDB-1:0] pat00, pat01;
  // LUT words, cycle N+1
  logic [MXOFFSB-1:0]       offs0, offs1;
  logic [MXBNDB-1:0]        bend0, bend1;
  logic [MXQLTB-1:0]        quality0, quality1;
  // Static configuration and control
  logic [MXQLTB-1:0]        qlt_thresh;
  logic [MXHITB-1:0]        hit_thresh;
  logic                     cnt_clear;
  // Registered CLCT outputs
  logic                     clct0_vld, clct1_vld;
  logic [MXKEYB+1:0]        clct0_key, clct1_key;
  logic [MXBNDB-1:0]        clct0_bnd, clct1_bnd;
  logic [MXQLTB-1:0]        clct0_qlt, clct1_qlt;
  logic [MXPIDB-1:0]        clct0_pid, clct1_pid;
  logic [MXHITB-1:0]        clct0_hit, clct1_hit;
  logic                     lock_busy;
  logic [MXCNTB-1:0]        cnt_accept, cnt_reject;

  modport master (
    output pat_vld0, pat_vld1, hs_key0, hs_key1, pat00, pat01,
           offs0, offs1, bend0, bend1, quality0, quality1,
           qlt_thresh, hit_thresh, cnt_clear,
    input  clct0_vld, clct1_vld, clct0_key, clct1_key, clct0_bnd, clct1_bnd,
           clct0_qlt, clct1_qlt, clct0_pid, clct1_pid, clct0_hit, clct1_hit,
           lock_busy, cnt_accept, cnt_reject
  );

  modport slave (
    input  pat_vld0, pat_vld1, hs_key0, hs_key1, pat00, pat01,
           offs0, offs1, bend0, bend1, quality0, quality1,
           qlt_thresh, hit_thresh, cnt_clear,
    output clct0_vld, clct1_vld, clct0_key, clct1_key, clct0_bnd, clct1_bnd,
           clct0_qlt, clct1_qlt, clct0_pid, clct1_pid, clct0_hit, clct1_hit,
           lock_busy, cnt_accept, cnt_reject
  );
endinterface

`default_nettype wire

// File: rtl/clct_cclut_builder.sv
// ============================================================================
// Module      : clct_cclut_builder
// Description : Aligns the two best pattern candidates with their ccLUT words,
//               builds eighth-strip keys, applies thresholds and dead time,
//               orders the pair by quality and keeps accept/reject counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clct_cclut_builder #(
  parameter int MXKEYB    = 8,
  parameter int NHS       = 224,
  parameter int MXHITB    = 3,
  parameter int MXPIDB    = 4,
  parameter int MXOFFSB   = 4,
  parameter int MXBNDB    = 5,
  parameter int MXQLTB    = 9,
  parameter int DEAD_TIME = 4,
  parameter int MXCNTB    = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  clct_cclut_builder_if.slave bus
);

  localparam int PATB   = MXHITB + MXPIDB;
  localparam int KEYB   = MXKEYB + 2;
  // One guard bit above the signed key width so that half-strip keys beyond
  // NHS clamp high instead of wrapping negative.
  localparam int ESB    = MXKEYB + 4;
  localparam int ES_MAX = 4 * NHS - 1;
  localparam int SLOTB  = KEYB + MXBNDB + MXQLTB + MXPIDB + MXHITB;
  localparam int LOCKB  = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;
  localparam logic [LOCKB-1:0] C_DEAD = LOCKB'(DEAD_TIME);

  // es_key = 4*hs_key + offs - 8, clamped to [0, 4*NHS-1]
  function automatic logic [KEYB-1:0] es_key(input logic [MXKEYB-1:0] hs,
                                             input logic [MXOFFSB-1:0] offs);
    logic signed [ESB-1:0] raw;
    raw = $signed({2'b00, hs, 2'b00}) + $signed({{(ESB-MXOFFSB){1'b0}}, offs})
        - $signed(ESB'(8));
    if (raw[ESB-1])                          es_key = '0;
    else if (raw > $signed(ESB'(ES_MAX)))    es_key = KEYB'(ES_MAX);
    else                                     es_key = raw[KEYB-1:0];
  endfunction

  // Saturating add of 0..2 events
  function automatic logic [MXCNTB-1:0] sat_add(input logic [MXCNTB-1:0] cnt,
                                                input logic [1:0] inc);
    logic [MXCNTB:0] sum;
    sum = {1'b0, cnt} + {{(MXCNTB-1){1'b0}}, inc};
    sat_add = sum[MXCNTB] ? '1 : sum[MXCNTB-1:0];
  endfunction

  logic [1:0]        r_s0_vld;
  logic [MXKEYB-1:0] r_s0_key0, r_s0_key1;
  logic [PATB-1:0]   r_s0_pat0, r_s0_pat1;

  logic [LOCKB-1:0]  r_lock;
  logic              r_busy;
  logic              r_vld0, r_vld1;
  logic [SLOTB-1:0]  r_slot0, r_slot1;
  logic [MXCNTB-1:0] r_cnt_acc, r_cnt_rej;

  logic              w_pass0, w_pass1, w_swap;
  logic              w_vld0, w_vld1;
  logic [SLOTB-1:0]  w_cand0, w_cand1, w_slot0, w_slot1;
  logic [1:0]        w_n_acc, w_n_rej;
  logic [LOCKB-1:0]  w_lock_nxt;

  // Stage 0: capture the pattern candidates
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s0_vld  <= '0;
      r_s0_key0 <= '0;
      r_s0_key1 <= '0;
      r_s0_pat0 <= '0;
      r_s0_pat1 <= '0;
    end else begin
      r_s0_vld  <= {bus.pat_vld1, bus.pat_vld0};
      r_s0_key0 <= bus.hs_key0;
      r_s0_key1 <= bus.hs_key1;
      r_s0_pat0 <= bus.pat00;
      r_s0_pat1 <= bus.pat01;
    end
  end

  // Stage 1: merge with LUT words, qualify, order and compute lock/counter updates
  always_comb begin
    w_cand0 = {es_key(r_s0_key0, bus.offs0), bus.bend0, bus.quality0,
               r_s0_pat0[MXPIDB-1:0], r_s0_pat0[PATB-1 -: MXHITB]};
    w_cand1 = {es_key(r_s0_key1, bus.offs1), bus.bend1, bus.quality1,
               r_s0_pat1[MXPIDB-1:0], r_s0_pat1[PATB-1 -: MXHITB]};

    w_pass0 = r_s0_vld[0] && (r_s0_pat0[PATB-1 -: MXHITB] >= bus.hit_thresh)
              && (bus.quality0 >= bus.qlt_thresh) && (r_lock == '0);
    w_pass1 = r_s0_vld[1] && (r_s0_pat1[PATB-1 -: MXHITB] >= bus.hit_thresh)
              && (bus.quality1 >= bus.qlt_thresh) && (r_lock == '0);
    w_swap  = bus.quality1 > bus.quality0;

    w_vld0  = 1'b0;
    w_vld1  = 1'b0;
    w_slot0 = '0;
    w_slot1 = '0;
    if (w_pass0 && w_pass1) begin
      w_vld0  = 1'b1;
      w_vld1  = 1'b1;
      w_slot0 = w_swap ? w_cand1 : w_cand0;
      w_slot1 = w_swap ? w_cand0 : w_cand1;
    end else if (w_pass0) begin
      w_vld0  = 1'b1;
      w_slot0 = w_cand0;
    end else if (w_pass1) begin
      w_vld0  = 1'b1;
      w_slot0 = w_cand1;
    end

    w_n_acc = {1'b0, w_pass0} + {1'b0, w_pass1};
    w_n_rej = {1'b0, r_s0_vld[0] & ~w_pass0} + {1'b0, r_s0_vld[1] & ~w_pass1};

    if (w_pass0 || w_pass1)  w_lock_nxt = C_DEAD;
    else if (r_lock != '0)   w_lock_nxt = r_lock - 1'b1;
    else                     w_lock_nxt = r_lock;
  end

  // Output stage: registered CLCT pair, lockout state and event counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vld0    <= 1'b0;
      r_vld1    <= 1'b0;
      r_slot0   <= '0;
      r_slot1   <= '0;
      r_lock    <= '0;
      r_busy    <= 1'b0;
      r_cnt_acc <= '0;
      r_cnt_rej <= '0;
    end else begin
      r_vld0  <= w_vld0;
      r_vld1  <= w_vld1;
      r_slot0 <= w_slot0;
      r_slot1 <= w_slot1;
      r_lock  <= w_lock_nxt;
      r_busy  <= (w_lock_nxt != '0);
      if (bus.cnt_clear) begin
        r_cnt_acc <= '0;
        r_cnt_rej <= '0;
      end else begin
        r_cnt_acc <= sat_add(r_cnt_acc, w_n_acc);
        r_cnt_rej <= sat_add(r_cnt_rej, w_n_rej);
      end
    end
  end

  assign bus.clct0_vld = r_vld0;
  assign bus.clct1_vld = r_vld1;
  assign {bus.clct0_key, bus.clct0_bnd, bus.clct0_qlt, bus.clct0_pid, bus.clct0_hit} = r_slot0;
  assign {bus.clct1_key, bus.clct1_bnd, bus.clct1_qlt, bus.clct1_pid, bus.clct1_hit} = r_slot1;
  assign bus.lock_busy  = r_busy;
  assign bus.cnt_accept = r_cnt_acc;
  assign bus.cnt_reject = r_cnt_rej;

endmodule

`default_nettype wire

// File: tb/tb_clct_cclut_builder.sv
// ============================================================================
// Module      : tb_clct_cclut_builder
// Description : Directed self-checking bench for clct_cclut_builder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clct_cclut_builder;

  logic clock = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  clct_cclut_builder_if bus ();

  clct_cclut_builder #(.DEAD_TIME(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pat(input int c, input logic v, input logic [7:0] key,
                     input logic [2:0] hit, input logic [3:0] pid);
    if (c == 0) begin
      bus.pat_vld0 = v; bus.hs_key0 = key; bus.pat00 = {hit, pid};
    end else begin
      bus.pat_vld1 = v; bus.hs_key1 = key; bus.pat01 = {hit, pid};
    end
  endtask

  task automatic lut(input int c, input logic [3:0] o, input logic [4:0] b, input logic [8:0] q);
    if (c == 0) begin
      bus.offs0 = o; bus.bend0 = b; bus.quality0 = q;
    end else begin
      bus.offs1 = o; bus.bend1 = b; bus.quality1 = q;
    end
  endtask

  task automatic clr();
    pat(0, 1'b0, 8'd0, 3'd0, 4'd0);
    pat(1, 1'b0, 8'd0, 3'd0, 4'd0);
    lut(0, 4'd0, 5'd0, 9'd0);
    lut(1, 4'd0, 5'd0, 9'd0);
  endtask

  // Directed sequence
  initial begin
    clr();
    bus.qlt_thresh = 9'd0;
    bus.hit_thresh = 3'd0;
    bus.cnt_clear  = 1'b0;
    reset_n        = 1'b0;
    idle(3);
    check("rst_vld0", 32'(bus.clct0_vld), 32'd0);
    check("rst_key0", 32'(bus.clct0_key), 32'd0);
    check("rst_acc",  32'(bus.cnt_accept), 32'd0);
    check("rst_busy", 32'(bus.lock_busy), 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Single candidate: key 4*10+9-8 = 41
    pat(0, 1'b1, 8'd10, 3'd6, 4'hA);
    tick(); clr(); lut(0, 4'd9, 5'd3, 9'd100);
    tick(); clr();
    check("one_vld0", 32'(bus.clct0_vld), 32'd1);
    check("one_key0", 32'(bus.clct0_key), 32'd41);
    check("one_pid0", 32'(bus.clct0_pid), 32'hA);
    check("one_hit0", 32'(bus.clct0_hit), 32'd6);
    check("one_qlt0", 32'(bus.clct0_qlt), 32'd100);
    check("one_bnd0", 32'(bus.clct0_bnd), 32'd3);
    check("one_vld1", 32'(bus.clct1_vld), 32'd0);
    check("one_acc",  32'(bus.cnt_accept), 32'd1);
    check("one_busy", 32'(bus.lock_busy), 32'd1);
    idle(3);
    check("dead_busy3", 32'(bus.lock_busy), 32'd1);
    tick();
    check("dead_busy4", 32'(bus.lock_busy), 32'd0);
    check("idle_vld0",  32'(bus.clct0_vld), 32'd0);

    // Swap: c0 key 80 q50, c1 key 116 q80
    pat(0, 1'b1, 8'd20, 3'd5, 4'd1);
    pat(1, 1'b1, 8'd30, 3'd4, 4'd2);
    tick(); clr(); lut(0, 4'd8, 5'd1, 9'd50); lut(1, 4'd4, 5'd2, 9'd80);
    tick(); clr();
    check("swp_qlt0", 32'(bus.clct0_qlt), 32'd80);
    check("swp_key0", 32'(bus.clct0_key), 32'd116);
    check("swp_pid0", 32'(bus.clct0_pid), 32'd2);
    check("swp_vld1", 32'(bus.clct1_vld), 32'd1);
    check("swp_qlt1", 32'(bus.clct1_qlt), 32'd50);
    check("swp_key1", 32'(bus.clct1_key), 32'd80);
    check("swp_pid1", 32'(bus.clct1_pid), 32'd1);
    check("swp_acc",  32'(bus.cnt_accept), 32'd3);
    idle(4);

    // Equal quality: no swap
    pat(0, 1'b1, 8'd40, 3'd7, 4'd3);
    pat(1, 1'b1, 8'd50, 3'd7, 4'd4);
    tick(); clr(); lut(0, 4'd0, 5'd0, 9'd70); lut(1, 4'd0, 5'd0, 9'd70);
    tick(); clr();
    check("eq_pid0", 32'(bus.clct0_pid), 32'd3);
    check("eq_key0", 32'(bus.clct0_key), 32'd152);
    check("eq_pid1", 32'(bus.clct1_pid), 32'd4);
    check("eq_key1", 32'(bus.clct1_key), 32'd192);
    idle(4);

    // Low clamp: 0+0-8 -> 0
    pat(0, 1'b1, 8'd0, 3'd1, 4'd5);
    tick(); clr(); lut(0, 4'd0, 5'd0, 9'd10);
    tick(); clr();
    check("lo_vld0", 32'(bus.clct0_vld), 32'd1);
    check("lo_key0", 32'(bus.clct0_key), 32'd0);
    idle(4);

    // High clamp: 892+15-8 = 899 -> 895
    pat(0, 1'b1, 8'd223, 3'd1, 4'd6);
    tick(); clr(); lut(0, 4'd15, 5'd0, 9'd10);
    tick(); clr();
    check("hi_key0", 32'(bus.clct0_key), 32'd895);
    check("hi_acc",  32'(bus.cnt_accept), 32'd7);
    idle(4);

    // Quality threshold 60: c0 q59 rejected, c1 q60 (key 20) alone in slot 0
    bus.qlt_thresh = 9'd60;
    pat(0, 1'b1, 8'd100, 3'd6, 4'd7);
    pat(1, 1'b1, 8'd5, 3'd6, 4'd8);
    tick(); clr(); lut(0, 4'd0, 5'd0, 9'd59); lut(1, 4'd8, 5'd4, 9'd60);
    tick(); clr();
    check("qt_vld0", 32'(bus.clct0_vld), 32'd1);
    check("qt_pid0", 32'(bus.clct0_pid), 32'd8);
    check("qt_key0", 32'(bus.clct0_key), 32'd20);
    check("qt_bnd0", 32'(bus.clct0_bnd), 32'd4);
    check("qt_vld1", 32'(bus.clct1_vld), 32'd0);
    check("qt_rej",  32'(bus.cnt_reject), 32'd1);
    check("qt_acc",  32'(bus.cnt_accept), 32'd8);
    idle(4);

    // Hit threshold 4 with hit 3: rejected, no lockout
    bus.qlt_thresh = 9'd0;
    bus.hit_thresh = 3'd4;
    pat(0, 1'b1, 8'd100, 3'd3, 4'd9);
    tick(); clr(); lut(0, 4'd0, 5'd0, 9'd200);
    tick(); clr();
    check("ht_vld0", 32'(bus.clct0_vld), 32'd0);
    check("ht_key0", 32'(bus.clct0_key), 32'd0);
    check("ht_rej",  32'(bus.cnt_reject), 32'd2);
    check("ht_busy", 32'(bus.lock_busy), 32'd0);
    bus.hit_thresh = 3'd0;
    idle(1);

    // Lockout: candidate every cycle; 1st accepted, next 4 blocked, 6th accepted
    pat(0, 1'b1, 8'd10, 3'd6, 4'hB);
    tick();
    for (int k = 1; k <= 6; k++) begin
      clr();
      if (k <= 5) pat(0, 1'b1, 8'd10, 3'd6, 4'hB);
      lut(0, 4'd8, 5'd0, 9'd100);
      tick();
      check($sformatf("lk_vld%0d", k), 32'(bus.clct0_vld), (k == 1 || k == 6) ? 32'd1 : 32'd0);
      check($sformatf("lk_busy%0d", k), 32'(bus.lock_busy), (k != 5) ? 32'd1 : 32'd0);
    end
    clr();
    check("lk_acc", 32'(bus.cnt_accept), 32'd10);
    check("lk_rej", 32'(bus.cnt_reject), 32'd6);
    idle(4);

    // Clear wins over a same-cycle accept
    pat(0, 1'b1, 8'd10, 3'd6, 4'd1);
    tick(); clr(); lut(0, 4'd0, 5'd0, 9'd100); bus.cnt_clear = 1'b1;
    tick(); clr(); bus.cnt_clear = 1'b0;
    check("clr_vld0", 32'(bus.clct0_vld), 32'd1);
    check("clr_acc",  32'(bus.cnt_accept), 32'd0);
    check("clr_rej",  32'(bus.cnt_reject), 32'd0);
    idle(4);

    // Reject saturation: two rejects per cycle, 0 -> 0xFFFE -> 0xFFFF
    bus.qlt_thresh = 9'h1FF;
    pat(0, 1'b1, 8'd1, 3'd1, 4'd0);
    pat(1, 1'b1, 8'd1, 3'd1, 4'd0);
    repeat (32768) tick();
    check("sat_fffe", 32'(bus.cnt_reject), 32'hFFFE);
    tick();
    check("sat_ffff", 32'(bus.cnt_reject), 32'hFFFF);
    tick();
    check("sat_hold", 32'(bus.cnt_reject), 32'hFFFF);
    check("sat_acc",  32'(bus.cnt_accept), 32'd0);
    clr();
    idle(2);
    bus.qlt_thresh = 9'd0;

    // Reset while stage 0 holds a candidate
    pat(0, 1'b1, 8'd10, 3'd6, 4'd2);
    tick(); clr(); lut(0, 4'd8, 5'd0, 9'd100); pat(0, 1'b1, 8'd20, 3'd6, 4'd3);
    tick();
    check("pre_vld0", 32'(bus.clct0_vld), 32'd1);
    check("pre_key0", 32'(bus.clct0_key), 32'd40);
    clr(); lut(0, 4'd8, 5'd0, 9'd100);
    reset_n = 1'b0;
    #2;
    check("ar_vld0", 32'(bus.clct0_vld), 32'd0);
    check("ar_key0", 32'(bus.clct0_key), 32'd0);
    check("ar_acc",  32'(bus.cnt_accept), 32'd0);
    check("ar_rej",  32'(bus.cnt_reject), 32'd0);
    check("ar_busy", 32'(bus.lock_busy), 32'd0);
    #2;
    reset_n = 1'b1;
    tick();
    check("post_vld0a", 32'(bus.clct0_vld), 32'd0);
    check("post_acc",   32'(bus.cnt_accept), 32'd0);
    tick();
    check("post_vld0b", 32'(bus.clct0_vld), 32'd0);
    clr();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
